// File: rtl/seq_divide_pkg.sv
// Shared types for the seq_divide control stage.
// FSM state encoding, operand register bundle and default widths.
package seq_divide_pkg;

  localparam int unsigned DivWidthA = 32;
  localparam int unsigned DivWidthB = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } div_state_e;

  typedef struct packed {
    logic [DivWidthA-1:0] a;
    logic [DivWidthB-1:0] b;
    logic                 neg_q;
    logic                 neg_r;
  } div_req_t;

endpackage

// File: rtl/seq_divide_cneg.sv
// Conditional two's-complement negate: y_o = neg_i ? -x_i : x_i.
// Ports: x_i operand, neg_i negate enable, y_o result (modulo 2^Width).
module seq_divide_cneg #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] x_i,
  input  logic             neg_i,
  output logic [Width-1:0] y_o
);

  assign y_o = neg_i ? (~x_i + Width'(1)) : x_i;

endmodule

// File: rtl/seq_divide_ctrl.sv
// Request/response control around the seq_divide core: operand
// abs, core start/wait, result sign fix-up, local divide-by-zero.
// Ports: in_* request handshake + operands, out_* result handshake,
// core_* start/operands to the core and q/r/finish back from it,
// clk_i clock, rst_i synchronous active-high reset.
// Optional SEQ_DIVIDE_SIGNED_EN enables two's-complement operation;
// without it in_signed_i is ignored and everything is unsigned.
// WidthA/WidthB must match the package operand register widths.
module seq_divide_ctrl
  import seq_divide_pkg::*;
#(
  parameter int unsigned WidthA = DivWidthA,
  parameter int unsigned WidthB = DivWidthB
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WidthA-1:0] in_a_i,
  input  logic [WidthB-1:0] in_b_i,
  input  logic              in_signed_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WidthA-1:0] out_q_o,
  output logic [WidthB-1:0] out_r_o,
  output logic              out_dbz_o,
  output logic              core_start_o,
  output logic [WidthA-1:0] core_a_o,
  output logic [WidthB-1:0] core_b_o,
  input  logic [WidthA-1:0] core_q_i,
  input  logic [WidthB-1:0] core_r_i,
  input  logic              core_finish_i
);

  div_state_e state_q, state_d;
  div_req_t   req_q, req_d;

  logic [WidthA-1:0] q_q, q_d, q_fix, a_mag;
  logic [WidthB-1:0] r_q, r_d, r_fix, b_mag, dbz_r;
  logic              dbz_q, dbz_d;
  logic              sa, sb, b_zero;

`ifdef SEQ_DIVIDE_SIGNED_EN
  assign sa = in_signed_i & in_a_i[WidthA-1];
  assign sb = in_signed_i & in_b_i[WidthB-1];

  seq_divide_cneg #(.Width(WidthA)) u_abs_a (
    .x_i  (in_a_i),
    .neg_i(sa),
    .y_o  (a_mag)
  );

  seq_divide_cneg #(.Width(WidthB)) u_abs_b (
    .x_i  (in_b_i),
    .neg_i(sb),
    .y_o  (b_mag)
  );

  seq_divide_cneg #(.Width(WidthA)) u_fix_q (
    .x_i  (core_q_i),
    .neg_i(req_q.neg_q),
    .y_o  (q_fix)
  );

  seq_divide_cneg #(.Width(WidthB)) u_fix_r (
    .x_i  (core_r_i),
    .neg_i(req_q.neg_r),
    .y_o  (r_fix)
  );
`else
  logic unused_signed;
  assign unused_signed = ^{in_signed_i, req_q.neg_q, req_q.neg_r};
  assign sa    = 1'b0;
  assign sb    = 1'b0;
  assign a_mag = in_a_i;
  assign b_mag = in_b_i;
  assign q_fix = core_q_i;
  assign r_fix = core_r_i;
`endif

  // Divide-by-zero remainder is the dividend resized to WidthB;
  // sa doubles as the sign-extension bit.
  if (WidthA >= WidthB) begin : g_dbz_trunc
    assign dbz_r = in_a_i[WidthB-1:0];
  end else begin : g_dbz_ext
    assign dbz_r = {{(WidthB-WidthA){sa}}, in_a_i};
  end

  assign b_zero = (in_b_i == '0);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (b_zero) begin
            q_d     = '1;
            r_d     = dbz_r;
            dbz_d   = 1'b1;
            state_d = S_OUT;
          end else begin
            req_d.a     = a_mag;
            req_d.b     = b_mag;
            req_d.neg_q = sa ^ sb;
            req_d.neg_r = sa;
            state_d     = S_START;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (core_finish_i) begin
          q_d     = q_fix;
          r_d     = r_fix;
          dbz_d   = 1'b0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready_o   = (state_q == S_IDLE) & ~rst_i;
  assign out_valid_o  = (state_q == S_OUT);
  assign core_start_o = (state_q == S_START);
  assign core_a_o     = req_q.a;
  assign core_b_o     = req_q.b;
  assign out_q_o      = q_q;
  assign out_r_o      = r_q;
  assign out_dbz_o    = dbz_q;

endmodule

// File: tb/tb_seq_divide_ctrl.sv
// Directed bench for seq_divide_ctrl with a behavioural core model.
// Expected signed results depend on SEQ_DIVIDE_SIGNED_EN.
module tb_seq_divide_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_q, out_r;
  logic        out_dbz;
  logic        core_start;
  logic [31:0] core_a, core_b;
  logic [31:0] core_q = '0;
  logic [31:0] core_r = '0;
  logic        core_finish;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int busy = 0;

  always #5 clk = ~clk;

  seq_divide_ctrl #(.WidthA(32), .WidthB(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_signed_i  (in_signed),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_q_o      (out_q),
    .out_r_o      (out_r),
    .out_dbz_o    (out_dbz),
    .core_start_o (core_start),
    .core_a_o     (core_a),
    .core_b_o     (core_b),
    .core_q_i     (core_q),
    .core_r_i     (core_r),
    .core_finish_i(core_finish)
  );

  // Core model: busy for WidthB+1 cycles after start, then finish.
  assign core_finish = (busy == 0);
  always @(posedge clk) begin
    if (core_start) begin
      start_cnt <= start_cnt + 1;
      busy      <= 33;
      if (core_b != 0) begin
        core_q <= core_a / core_b;
        core_r <= core_a % core_b;
      end
    end else if (busy != 0) begin
      busy <= busy - 1;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issues one request and waits for the result (not consumed).
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, output int lat);
    int n;
    @(negedge clk);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) chk("timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat, s0;
    logic [31:0] hq, hr;

    vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 36};
    vecs[1] = '{32'h1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1};
    vecs[2] = '{32'hFFFFFFFF, 32'h10, 1'b0, 32'h0FFFFFFF, 32'hF, 1'b0, 36};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000,
                1'b0, 36};
`ifdef SEQ_DIVIDE_SIGNED_EN
    vecs[4] = '{32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE,
                1'b0, 36};
    vecs[5] = '{32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0, 36};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,
                1'b0, 36};
    vecs[7] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF,
                1'b0, 36};
`else
    vecs[4] = '{32'hFFFFFF9C, 32'd7, 1'b1, 32'h24924916, 32'd2, 1'b0, 36};
    vecs[5] = '{32'd100, 32'hFFFFFFF9, 1'b1, 32'd0, 32'd100, 1'b0, 36};
    vecs[6] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 32'h80000000,
                1'b0, 36};
    vecs[7] = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd0, 32'hFFFFFFF9,
                1'b0, 36};
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", out_q, 32'd0);
    chk("rst_r", out_r, 32'd0);
    chk("rst_dbz", {31'b0, out_dbz}, 32'd0);
    chk("rst_start", {31'b0, core_start}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, in_ready}, 32'd1);

    // Table vectors.
    for (int i = 0; i < 8; i++) begin
      s0 = start_cnt;
      issue(vecs[i].a, vecs[i].b, vecs[i].s, lat);
      chk($sformatf("v%0d_q", i), out_q, vecs[i].q);
      chk($sformatf("v%0d_r", i), out_r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), {31'b0, out_dbz}, {31'b0, vecs[i].dbz});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_starts", i), start_cnt - s0,
          vecs[i].dbz ? 32'd0 : 32'd1);
      consume();
    end

    // Backpressure: result held, no new accept, next accept right after.
    issue(32'd100, 32'd7, 1'b0, lat);
    hq = out_q;
    hr = out_r;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_q", out_q, hq);
      chk("bp_r", out_r, hr);
    end
    chk("bp_q_val", hq, 32'd14);
    chk("bp_r_val", hr, 32'd2);
    consume();
    @(negedge clk);
    chk("bp_next_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_valid_drop", {31'b0, out_valid}, 32'd0);

    // Reset while waiting on the core.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'd500;
    in_b = 32'd3;
    in_signed = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    issue(32'd100, 32'd7, 1'b0, lat);
    chk("after_rst_q", out_q, 32'd14);
    chk("after_rst_r", out_r, 32'd2);
    chk("after_rst_lat", lat, 32'd36);
    consume();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divide_ctrl.md
# seq_divide_ctrl

Request/response control stage directly upstream and downstream of the `seq_divide` core. It accepts operand requests on a valid/ready handshake and converts signed operands to magnitudes. It then drives the core's start/operand inputs, waits for `finish`, sign-corrects the quotient and remainder, and holds the result on a valid/ready output. Divide-by-zero is resolved locally without starting the core.

## Interface
- `WidthA`, 32, dividend/quotient width (matches core `WidthA`)
- `WidthB`, 32, divisor/remainder width (matches core `WidthB`)

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `in_valid_i`  in  1  request valid
- `in_ready_o`  out  1  request accepted when `in_valid_i & in_ready_o`
- `in_a_i`  in  WidthA  dividend
- `in_b_i`  in  WidthB  divisor
- `in_signed_i`  in  1  1 = two's-complement operation, 0 = unsigned
- `out_valid_o`  out  1  result valid
- `out_ready_i`  in  1  consumer accepts result
- `out_q_o`  out  WidthA  quotient
- `out_r_o`  out  WidthB  remainder
- `out_dbz_o`  out  1  result came from divide-by-zero
- `core_start_o`  out  1  to core `start_i`
- `core_a_o`  out  WidthA  to core `a_i` (magnitude)
- `core_b_o`  out  WidthB  to core `b_i` (magnitude)
- `core_q_i`  in  WidthA  from core `q_o`
- `core_r_i`  in  WidthB  from core `r_o`
- `core_finish_i`  in  1  from core `finish_o` (high when idle or done)

## Operation
- FSM states: IDLE, START, WAIT, OUT. `in_ready_o = (state == IDLE)`.
- IDLE, on accept with `in_b_i != 0`:
  - register `|a|`, `|b|`, `neg_q = sa ^ sb`, `neg_r = sa`.
  - `sa`/`sb` are the operand MSBs when signed, else 0.
  - go to START.
- IDLE, on accept with `in_b_i == 0`:
  - `q` = all ones; `r` = `in_a_i` resized to WidthB (sign-extended if signed, zero-extended otherwise; truncated if WidthA > WidthB); `dbz` = 1.
  - go to OUT.
- START: `core_start_o = 1` for exactly one cycle; go to WAIT.
- WAIT: on `core_finish_i == 1`, capture:
  - `q = neg_q ? -core_q_i : core_q_i`
  - `r = neg_r ? -core_r_i : core_r_i`
  - `dbz = 0`; go to OUT.
- OUT: `out_valid_o = 1`; on `out_ready_i` go to IDLE.
- `core_a_o`/`core_b_o` are driven from the operand register and held stable from START through WAIT. The core samples `b_i` every iteration.
- `core_start_o` is 0 in all states except START.
- Overflow: signed `-2^(WidthA-1) / -1` gives `q = -2^(WidthA-1)` (wrap), `r = 0`. No flag.
- Magnitude arithmetic is modulo 2^Width; the most-negative magnitude fits unsigned.

## Timing
- Reset values: `in_ready_o = 0` during reset, 1 in the first cycle after reset. `out_valid_o = 0`, `out_q_o = 0`, `out_r_o = 0`, `out_dbz_o = 0`, `core_start_o = 0`. State = IDLE.
- Normal path, accept in cycle 0:
  - START in cycle 1.
  - Core busy in cycles 2..WidthB+2; `core_finish_i` is low there.
  - Capture at the end of cycle WidthB+3.
  - `out_valid_o` in cycle WidthB+4, i.e. latency 36 at defaults.
- WAIT ignores `core_finish_i` only through the core's own timing: finish is guaranteed low in the cycle after START.
- Divide-by-zero: `out_valid_o` in cycle 1.
- Outputs are registered and held unchanged while `out_valid_o & !out_ready_i`.
- Throughput: one request per (latency + 1) cycles. The earliest next accept is the cycle after the output handshake.
- Reset mid-operation returns to IDLE next cycle and drops `out_valid_o`. A still-running core is harmless: the next START reloads it.

## Configuration
- `SEQ_DIVIDE_SIGNED_EN` defined: signed support as above.
- Not defined:
  - `in_signed_i` is ignored (treated as 0).
  - Negate/abs logic is removed; `neg_q`/`neg_r` are constant 0.
  - Divide-by-zero `r` is zero-extended.

## Structure
- Package `seq_divide_pkg`:
  - FSM state enum typedef `div_state_e`.
  - Struct `div_req_t` (`a`, `b`, `neg_q`, `neg_r`).
- One sub-module `seq_divide_cneg #(Width)`: conditional two's-complement negate (`y = neg ? -x : x`). Used for operand abs and result fix-up.

## Test plan
- Unsigned 100/7, `in_signed_i=0` -> `q=14`, `r=2`, `dbz=0`, `out_valid_o` exactly 36 cycles after accept.
- Signed -100/7 -> `q=0xFFFFFFF2`, `r=0xFFFFFFFE`. Signed 100/-7 -> `q=0xFFFFFFF2`, `r=2`.
- Signed 0x80000000 / 0xFFFFFFFF -> `q=0x80000000`, `r=0`, no flag.
- `b=0`, `a=0x1234` -> `q=0xFFFFFFFF`, `r=0x1234`, `dbz=1`, valid 1 cycle after accept, `core_start_o` never asserted.
- Backpressure: hold `out_ready_i=0` for 5 cycles -> outputs stable, `in_ready_o=0`. Next accept occurs the cycle after the handshake.
- Assert `rst_i` in WAIT -> `out_valid_o=0`, `in_ready_o=1` the next cycle. A following 100/7 request returns `q=14`, `r=2`.
